// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command initiator for the 8-bit ALU.
// Accepts one command at a time, drives it onto the ALU, samples the ALU
// outputs after LATENCY cycles, compares them against an internal golden
// model and returns the captured result plus a mismatch flag.
// LATENCY must lie in 1..15 so that it fits the 4-bit countdown.
module alu_cmd_driver #(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  input  logic       alu_parity,
  input  logic       alu_overflow,
  input  logic       alu_greater,
  input  logic       alu_less,
  input  logic       alu_is_eq,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [4:0] rsp_flags,
  output logic       rsp_mismatch,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [7:0]  rsp_y_q, rsp_y_d;
  logic [4:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_mismatch_q, rsp_mismatch_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic [12:0] golden_s;
  logic [12:0] observed_s;
  logic        mismatch_s;

  // Even-parity helper: XOR reduction of an 8-bit value.
  function automatic logic parity8(input logic [7:0] v);
    return ^v;
  endfunction

  // Reference ALU: returns {y, parity, overflow, greater, less, is_eq}.
  function automatic logic [12:0] golden(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] y;
    logic       ov;
    y  = 8'h00;
    ov = 1'b0;
    case (op)
      2'b00: begin
        y  = a + b;
        ov = (a[7] == b[7]) && (y[7] != a[7]);
      end
      2'b01: begin
        y  = a - b;
        ov = (a[7] != b[7]) && (y[7] != a[7]);
      end
      2'b10: begin
        y  = a & b;
        ov = 1'b0;
      end
      2'b11: begin
        y  = a | b;
        ov = 1'b0;
      end
      default: begin
        y  = 8'h00;
        ov = 1'b0;
      end
    endcase
    return {y, parity8(y), ov, (a > b), (a < b), (a == b)};
  endfunction

  // Golden result is always derived from the operands actually on the ALU.
  always_comb begin
    golden_s   = golden(alu_op_q, alu_a_q, alu_b_q);
    observed_s = {alu_y, alu_parity, alu_overflow, alu_greater, alu_less, alu_is_eq};
    mismatch_s = (observed_s != golden_s);
  end

  // Next-state and datapath-load decisions for the IDLE/DRIVE/HOLD sequence.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_op_d       = alu_op_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    rsp_y_d        = rsp_y_q;
    rsp_flags_d    = rsp_flags_q;
    rsp_mismatch_d = rsp_mismatch_q;
    err_cnt_d      = err_cnt_q;
    cmd_ready_d    = 1'b0;
    rsp_valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_op_d = cmd_op;
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          cnt_d    = LAT_CNT;
          state_d  = ST_DRIVE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        // Treat a zero count like one so a bad count can never stall here.
        if (cnt_q <= 4'd1) begin
          rsp_y_d        = alu_y;
          rsp_flags_d    = observed_s[4:0];
          rsp_mismatch_d = mismatch_s;
          if (mismatch_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_HOLD;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Handshake outputs are registered images of the upcoming state.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_HOLD);
  end

  // State, countdown, ALU drive and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      alu_op_q       <= 2'd0;
      alu_a_q        <= 8'h00;
      alu_b_q        <= 8'h00;
      rsp_y_q        <= 8'h00;
      rsp_flags_q    <= 5'd0;
      rsp_mismatch_q <= 1'b0;
      err_cnt_q      <= 8'h00;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      rsp_y_q        <= rsp_y_d;
      rsp_flags_q    <= rsp_flags_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      err_cnt_q      <= err_cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_flags    = rsp_flags_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Testbench for alu_cmd_driver: table-driven vectors through a scoreboard,
// plus hand-written backpressure, reset-abort and saturation sequences.
module tb_alu_cmd_driver;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_y;
  logic       alu_parity, alu_overflow, alu_greater, alu_less, alu_is_eq;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;
  logic       rsp_mismatch;
  logic [7:0] err_cnt;
  logic       fault = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       fault;
    logic [7:0] exp_y;
    logic [4:0] exp_flags;
    logic       exp_mis;
    int         stall;
    logic       hold_valid;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [4:0] flags;
    logic       mis;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  // Bench ALU: {y, parity, overflow, greater, less, is_eq} via integer arithmetic.
  function automatic logic [12:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb_i, r;
    logic [7:0] y;
    logic ov;
    sa = int'($signed(a));
    sb_i = int'($signed(b));
    r = 0;
    ov = 1'b0;
    case (op)
      2'd0: r = sa + sb_i;
      2'd1: r = sa - sb_i;
      2'd2: r = int'(a & b);
      default: r = int'(a | b);
    endcase
    y = r[7:0];
    if (op < 2'd2) ov = (r > 127) || (r < -128);
    return {y, ^y, ov, a > b, a < b, a == b};
  endfunction

  logic [12:0] model_s;
  assign model_s      = ref_alu(alu_op, alu_a, alu_b);
  assign alu_y        = model_s[12:5] ^ (fault ? 8'h08 : 8'h00);
  assign alu_parity   = model_s[4];
  assign alu_overflow = model_s[3];
  assign alu_greater  = model_s[2];
  assign alu_less     = model_s[1];
  assign alu_is_eq    = model_s[0];

  alu_cmd_driver #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
    .alu_greater(alu_greater), .alu_less(alu_less), .alu_is_eq(alu_is_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_mismatch(rsp_mismatch),
    .err_cnt(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu"}, {14'd0, alu_op, alu_a, alu_b}, 32'd0);
    check({tag, "_rsp"}, {18'd0, rsp_y, rsp_flags, rsp_mismatch}, 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  // One full transaction: accept, busy phase, response, optional stall, handshake.
  task automatic run_cmd(input vec_t v);
    int guard;
    exp_t e, got;
    logic [13:0] snap;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = v.op;
    cmd_a = v.a;
    cmd_b = v.b;
    fault = v.fault;
    rsp_ready = 1'b0;
    e.y = v.exp_y;
    e.flags = v.exp_flags;
    e.mis = v.exp_mis;
    sb.push_back(e);
    @(posedge clk);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (v.hold_valid) cmd_a = ~v.a;
      else cmd_valid = 1'b0;
      check("busy_rsp_valid", 32'(rsp_valid), 32'd0);
      check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      check("busy_alu", {14'd0, alu_op, alu_a, alu_b}, {14'd0, v.op, v.a, v.b});
    end
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    snap = {rsp_y, rsp_flags, rsp_mismatch};
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_rsp_stable", 32'({rsp_y, rsp_flags, rsp_mismatch}), 32'(snap));
    end
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      got = sb.pop_front();
      if (got.mis && exp_err < 255) exp_err++;
      check("rsp_y", 32'(rsp_y), 32'(got.y));
      check("rsp_flags", 32'(rsp_flags), 32'(got.flags));
      check("rsp_mismatch", 32'(rsp_mismatch), 32'(got.mis));
      check("err_cnt", 32'(err_cnt), 32'(exp_err));
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [12:0] r;
    logic [7:0] pre_err;
    logic seen;
    //          op     a      b      flt   exp_y  flags      mis  stall hv
    vecs[0] = '{2'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 5'b11100, 1'b0, 0, 1'b0};
    vecs[1] = '{2'd1, 8'h05, 8'h05, 1'b0, 8'h00, 5'b00001, 1'b0, 0, 1'b0};
    vecs[2] = '{2'd2, 8'hF0, 8'h3C, 1'b1, 8'h38, 5'b00100, 1'b1, 0, 1'b0};
    vecs[3] = '{2'd3, 8'h0F, 8'hF0, 1'b0, 8'hFF, 5'b00010, 1'b0, 5, 1'b1};
    vecs[4] = '{2'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 5'b11100, 1'b0, 0, 1'b0};
    vecs[5] = '{2'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 5'b00100, 1'b0, 0, 1'b0};
    vecs[6] = '{2'd1, 8'h01, 8'h02, 1'b0, 8'hFF, 5'b00010, 1'b0, 2, 1'b0};
    vecs[7] = '{2'd2, 8'hAA, 8'h55, 1'b0, 8'h00, 5'b00100, 1'b0, 0, 1'b0};
    vecs[8] = '{2'd0, 8'h80, 8'h80, 1'b0, 8'h00, 5'b01001, 1'b0, 0, 1'b0};
    vecs[9] = '{2'd3, 8'h12, 8'h12, 1'b1, 8'h1A, 5'b00001, 1'b1, 0, 1'b0};

    // Reset state while rst is held.
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i]);
    end

    // Reset abort during DRIVE: outputs clear asynchronously, no response.
    @(negedge clk);
    pre_err = err_cnt;
    check("abort_pre_err_nonzero", 32'(pre_err != 8'h00), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_a = 8'h11;
    cmd_b = 8'h22;
    fault = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("abort");
    exp_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    run_cmd(vecs[0]);
    run_cmd(vecs[9]);

    // Saturation: 260 forced mismatches drive err_cnt to 255 and hold it.
    for (int i = 0; i < 260; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a = 8'($urandom_range(0, 255));
      v.b = 8'($urandom_range(0, 255));
      r = ref_alu(v.op, v.a, v.b);
      v.fault = 1'b1;
      v.exp_y = r[12:5] ^ 8'h08;
      v.exp_flags = r[4:0];
      v.exp_mis = 1'b1;
      v.stall = 0;
      v.hold_valid = 1'b0;
      run_cmd(v);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential initiator for the 8-bit ALU datapath (op/a/b in; y, parity, overflow, greater, less, is_eq out). The block accepts commands over a valid/ready port and drives one operation at a time onto the ALU inputs. It samples the ALU outputs after a fixed latency and recomputes the golden result internally. It returns the captured result plus a mismatch flag over a second valid/ready port. It sits between the test/command sequencer and the (possibly ECO-patched) ALU, and serves as an in-system self-check of that ALU.

## Interface
- LATENCY, 1, ALU output sample delay in cycles, measured from the first cycle operands are driven. Legal range is 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  opcode: 00 add, 01 sub (a-b), 10 and, 11 or.
- cmd_a, cmd_b  in  8  operands.
- alu_op  out  2  registered opcode to ALU.
- alu_a, alu_b  out  8  registered operands to ALU.
- alu_y  in  8  ALU result.
- alu_parity, alu_overflow, alu_greater, alu_less, alu_is_eq  in  1  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  8  captured alu_y.
- rsp_flags  out  5  captured {parity, overflow, greater, less, is_eq}.
- rsp_mismatch  out  1  captured result differs from the golden result.
- err_cnt  out  8  saturating count of mismatching responses.

## Operation
- State machine: IDLE -> DRIVE -> HOLD -> IDLE.
- **IDLE**
  - cmd_ready=1.
  - When cmd_valid=1: register op/a/b onto alu_*, load cnt=LATENCY, go to DRIVE.
- **DRIVE**
  - cmd_ready=0; alu_* held stable.
  - cnt decrements each cycle.
  - In the cycle where cnt==1: capture alu_y and the flags into rsp_*, compute rsp_mismatch, update err_cnt, go to HOLD.
- **HOLD**
  - rsp_valid=1; rsp_* held stable.
  - When rsp_ready=1: go to IDLE.
  - cmd_ready stays 0 in HOLD; there is no same-cycle turnaround.
- **Golden model** (combinational from the registered alu_* values)
  - y = 8-bit truncation of a+b, a-b, a&b, or a|b, per opcode.
  - parity = XOR-reduce(y).
  - overflow = signed two's-complement overflow for add/sub; 0 for and/or.
  - greater = a>b, less = a<b, is_eq = a==b. All three are unsigned and independent of op.
- **Mismatch**: rsp_mismatch=1 if y differs or any of the 5 flags differs.
- **err_cnt**
  - Increments by 1 on each captured mismatch.
  - Saturates at 255; never wraps.
  - Cleared only by rst.
- **alu_* outputs**: hold their last value in IDLE and HOLD; they change only on command acceptance.

## Timing
- **Reset values** (asynchronous, while rst=1):
  - state=IDLE, cmd_ready=1, rsp_valid=0.
  - alu_op=0, alu_a=0, alu_b=0.
  - rsp_y=0, rsp_flags=0, rsp_mismatch=0.
  - err_cnt=0, cnt=0.
- **Latency** (command accepted at edge 0):
  - alu_* valid from cycle 1.
  - ALU outputs sampled at the end of cycle LATENCY.
  - rsp_valid=1 from cycle LATENCY+1.
- **Throughput**: at most one command per LATENCY+2 cycles with rsp_ready tied high.
- **Backpressure**: rsp_ready low holds HOLD indefinitely; all rsp_* stay stable and cmd_ready stays 0.
- **Reset mid-operation**: rst in DRIVE or HOLD aborts the transaction. No response is produced and err_cnt is cleared.
- **LATENCY=1**: DRIVE lasts exactly one cycle.
- **cnt width**: 4 bits.
- **Handshake rules**
  - cmd_valid is ignored while cmd_ready=0.
  - A producer may drop cmd_valid without penalty.

## Test plan
- **Add with overflow**: op=00, a=0x7F, b=0x01, correct ALU.
  - Response: rsp_y=0x80, flags {parity=1, overflow=1, greater=1, less=0, is_eq=0}, mismatch=0.
  - rsp_valid rises at cycle LATENCY+1 (cycle 2 for LATENCY=1).
- **Equal subtract**: op=01, a=0x05, b=0x05.
  - Response: rsp_y=0x00, flags {0,0,0,0,1}, mismatch=0.
  - err_cnt unchanged.
- **Fault injection**: bench ALU model forces y bit 3 inverted on op=10, a=0xF0, b=0x3C.
  - Response: rsp_y=0x38 (golden 0x30), rsp_mismatch=1, err_cnt 0 -> 1.
- **Backpressure**: hold rsp_ready=0 for 5 cycles after rsp_valid rises, with cmd_valid=1 throughout.
  - rsp_* stable and cmd_ready=0 for all 5 cycles.
  - The next command is accepted only in the cycle after the rsp handshake.
- **Reset abort**: assert rst during DRIVE with LATENCY=4.
  - All outputs take reset values immediately and asynchronously.
  - No rsp_valid pulse; the next command after rst release behaves normally.
- **Saturation**: run 260 forced-mismatch commands.
  - err_cnt reaches 255 and stays 255; rsp_mismatch=1 on every response.
